bl_pulse_sequencer: RTL and testbench
=====================================

// Module: bl_pulse_sequencer
// PURPOSE
//  Parametrised bitline driver for the array: generalises the addressed/broadcast bitline write to NUM_BL lines fed by NUM_SRC DAC levels.
//  Adds command handshake, timed write pulses with automatic return to a rest level, auto-increment sweeps and abort.
//  Sits between the array-control FSM (commands) and the analog bitline model (real-valued outputs).
// PARAMETERS
//  NUM_BL    32   bitline count; power of 2, multiple of NUM_SRC
//  NUM_SRC   8    DAC level inputs; power of 2
//  PW_W      8    pulse-width field width
//  REST_VOL  0.0  (real) rest level driven at reset, after each pulse and by CLEAR
//  AW = $clog2(NUM_BL) (localparam)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        async active-low reset
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        block idle, command accepted when valid&ready
//  cmd_op     in   2        00 WRITE, 01 BCAST, 10 SWEEP, 11 CLEAR
//  cmd_addr   in   AW       first bitline (WRITE/SWEEP)
//  cmd_len    in   AW+1     SWEEP line count, 1..NUM_BL
//  cmd_pw     in   PW_W     pulse width in cycles; 0 = persistent level
//  abort      in   1        sync abort of active command
//  op_vol     in   real[NUM_SRC]  DAC levels
//  bl_out     out  real[NUM_BL]   registered bitline levels
//  busy       out  1        state != IDLE
//  done       out  1        1-cycle pulse, command finished
//  err        out  1        1-cycle pulse with done: rejected or aborted
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, all bl_out = REST_VOL, done/err/busy=0, cmd_ready=1; applies at any point mid-command.
//  Accept (cycle T): latch op, addr, len, pw; snapshot op_vol into vol_reg. Later op_vol changes are ignored until next accept.
//  Level for line i = vol_reg[i % NUM_SRC] (low log2(NUM_SRC) address bits).
//  FSM states: IDLE, APPLY, HOLD, RESTORE, DONE.
//   IDLE: cmd_ready=1; on accept -> APPLY, or -> DONE with err if SWEEP and (cmd_len==0 or cmd_len>NUM_BL).
//   APPLY (1 cycle): drive target(s): WRITE cur line; BCAST all lines; SWEEP cur line; CLEAR all lines = REST_VOL.
//    Then: CLEAR or pw==0 -> NEXT; pw==1 -> RESTORE; else -> HOLD with cnt=pw-2.
//   HOLD: cnt-- each cycle; at cnt==0 -> RESTORE.
//   RESTORE (1 cycle): same targets <= REST_VOL, then -> NEXT.
//   NEXT (decision, no cycle): SWEEP with remaining>1: cur=(cur+1) mod NUM_BL (wraps NUM_BL-1 -> 0), remaining--, -> APPLY; else -> DONE.
//   DONE (1 cycle): done=1 (err as flagged) -> IDLE.
//  Timing: WRITE accepted at T: new level visible T+2; pw=0: done in T+2, cmd_ready in T+3.
//   pw=N>0: level visible exactly N cycles (T+2..T+N+1), REST_VOL from T+N+2, done in T+N+2.
//   SWEEP: each line pulses in turn, no overlap; pw=0 leaves all swept lines at their levels; per-line cost = max(pw,1)+(pw>0).
//  Untouched lines hold their value in every state.
//  abort (sampled when busy): APPLY/HOLD of a pulse (pw>0) -> RESTORE then DONE; otherwise -> DONE directly; sweep terminated; err=1 with done.
//   abort in IDLE ignored; abort same cycle as RESTORE completes: RESTORE finishes, then DONE with err.
//  cmd_valid while busy: not accepted (cmd_ready=0), no effect.
// TESTING
//  1 reset then WRITE addr=5 pw=0, op_vol[5]=1.2 -> bl_out[5]=1.2 at T+2, others 0.0, done at T+2, err=0.
//  2 WRITE addr=13 pw=4, op_vol[5]=0.8 -> bl_out[13]=0.8 cycles T+2..T+5, 0.0 at T+6, done at T+6.
//  3 SWEEP addr=30 len=4 pw=0 -> lines 30,31,0,1 = op_vol[6],[7],[0],[1]; done once at end.
//  4 BCAST pw=2 then change op_vol mid-pulse -> all 32 lines = snapshot values 2 cycles, then REST_VOL; changes ignored.
//  5 SWEEP len=0 and len=33 -> done+err next cycle, bl_out unchanged; cmd_valid during busy not accepted.
//  6 SWEEP pw=8, abort in HOLD of 2nd line -> that line restored next cycle, done+err, remaining lines untouched; rst_n low mid-HOLD -> all REST_VOL immediately.

Source files
------------

// File: rtl/bl_pulse_sequencer.sv
// bl_pulse_sequencer: command-driven bitline driver. Accepts WRITE / BCAST /
// SWEEP / CLEAR commands, snapshots the DAC levels, drives the addressed
// line(s) for a timed pulse and then returns them to the rest level.
module bl_pulse_sequencer #(
   parameter int  NUM_BL   = 32,
   parameter int  NUM_SRC  = 8,
   parameter int  PW_W     = 8,
   parameter real REST_VOL = 0.0,
   localparam int AW       = $clog2(NUM_BL)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [AW:0]     cmd_len,
   input  logic [PW_W-1:0] cmd_pw,
   input  logic            abort,
   input  real             op_vol [NUM_SRC],
   output real             bl_out [NUM_BL],
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_BCAST = 2'b01;
   localparam logic [1:0] OP_SWEEP = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_HOLD,
      S_RESTORE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [1:0]      r_op;
   logic [AW-1:0]   r_cur;
   logic [AW:0]     r_rem;
   logic [PW_W-1:0] r_pw;
   logic [PW_W-1:0] r_cnt;
   logic            r_err;   // rejected at accept, or abort seen while active
   real             r_vol [NUM_SRC];

   logic            w_accept;
   logic            w_reject;
   logic            w_persist;   // level stays after APPLY (no pulse)
   logic            w_more;      // sweep has further lines to visit
   logic            w_step;
   logic            w_load_cnt;
   logic            w_abort_hit;
   logic            w_drive;
   logic            w_apply_lvl;
   logic [NUM_BL-1:0] w_tgt;

   assign w_accept    = cmd_valid && (r_state == S_IDLE);
   assign w_reject    = (cmd_op == OP_SWEEP) &&
                        ((cmd_len == '0) || (cmd_len > (AW+1)'(NUM_BL)));
   assign w_persist   = (r_op == OP_CLEAR) || (r_pw == '0);
   assign w_more      = (r_op == OP_SWEEP) && (r_rem > (AW+1)'(1));
   assign w_drive     = (r_state == S_APPLY) || (r_state == S_RESTORE);
   assign w_apply_lvl = (r_state == S_APPLY) && (r_op != OP_CLEAR);

   // Per-line target decode: broadcast ops hit every line, others the cursor.
   generate
      for (genvar gi = 0; gi < NUM_BL; gi++) begin : g_tgt
         assign w_tgt[gi] = (r_op == OP_BCAST) || (r_op == OP_CLEAR) ||
                            (r_cur == AW'(gi));
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      w_state_next = r_state;
      w_step       = 1'b0;
      w_load_cnt   = 1'b0;
      w_abort_hit  = 1'b0;
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      err          = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) w_state_next = w_reject ? S_DONE : S_APPLY;
         end
         S_APPLY: begin
            if (abort) begin
               w_abort_hit  = 1'b1;
               w_state_next = w_persist ? S_DONE : S_RESTORE;
            end else if (w_persist) begin
               if (w_more) begin
                  w_step       = 1'b1;
                  w_state_next = S_APPLY;
               end else begin
                  w_state_next = S_DONE;
               end
            end else if (r_pw == PW_W'(1)) begin
               w_state_next = S_RESTORE;
            end else begin
               w_load_cnt   = 1'b1;
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (abort) begin
               w_abort_hit  = 1'b1;
               w_state_next = S_RESTORE;
            end else if (r_cnt == '0) begin
               w_state_next = S_RESTORE;
            end
         end
         S_RESTORE: begin
            // A pending abort (now or earlier) ends the command after restore.
            if (abort || r_err) begin
               w_abort_hit  = abort;
               w_state_next = S_DONE;
            end else if (w_more) begin
               w_step       = 1'b1;
               w_state_next = S_APPLY;
            end else begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            err          = r_err;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Command latch, level snapshot, sweep cursor and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= OP_WRITE;
         r_cur <= '0;
         r_rem <= '0;
         r_pw  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) r_vol[i] <= REST_VOL;
      end else if (w_accept) begin
         r_op  <= cmd_op;
         r_cur <= cmd_addr;
         r_rem <= cmd_len;
         r_pw  <= cmd_pw;
         r_err <= w_reject;
         for (int i = 0; i < NUM_SRC; i++) r_vol[i] <= op_vol[i];
      end else begin
         if (w_abort_hit) r_err <= 1'b1;
         if (w_step) begin
            r_cur <= r_cur + AW'(1);       // power-of-2 count wraps naturally
            r_rem <= r_rem - (AW+1)'(1);
         end
         if (w_load_cnt)             r_cnt <= r_pw - PW_W'(2);
         else if (r_state == S_HOLD) r_cnt <= r_cnt - PW_W'(1);
      end
   end

   // Bitline registers: targeted lines take the level in APPLY, rest in RESTORE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BL; i++) bl_out[i] <= REST_VOL;
      end else begin
         for (int i = 0; i < NUM_BL; i++) begin
            if (w_drive && w_tgt[i])
               bl_out[i] <= w_apply_lvl ? r_vol[i % NUM_SRC] : REST_VOL;
         end
      end
   end

endmodule

// File: tb/tb_bl_pulse_sequencer.sv
// Directed testbench for bl_pulse_sequencer: hand-computed expectations,
// immediate assertions at every comparison point.
module tb_bl_pulse_sequencer;
   localparam int NUM_BL  = 32;
   localparam int NUM_SRC = 8;
   localparam int PW_W    = 8;
   localparam int AW      = 5;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_BCAST = 2'b01;
   localparam logic [1:0] OP_SWEEP = 2'b10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_op;
   logic [AW-1:0]   cmd_addr;
   logic [AW:0]     cmd_len;
   logic [PW_W-1:0] cmd_pw;
   logic            abort;
   real             op_vol [NUM_SRC];
   real             bl_out [NUM_BL];
   logic            busy;
   logic            done;
   logic            err;

   int checks = 0;
   int errors = 0;

   bl_pulse_sequencer #(
      .NUM_BL(NUM_BL), .NUM_SRC(NUM_SRC), .PW_W(PW_W), .REST_VOL(0.0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_pw(cmd_pw),
      .abort(abort), .op_vol(op_vol), .bl_out(bl_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_r(input string tag, input real obs, input real exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command for one cycle; returns one cycle after the accept edge (T+1).
   task automatic issue(input logic [1:0] op, input int addr, input int len, input int pw);
      cmd_op    = op;
      cmd_addr  = AW'(addr);
      cmd_len   = (AW+1)'(len);
      cmd_pw    = PW_W'(pw);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int dcount;
      int done_at;
      int bad;

      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_addr  = '0;
      cmd_len   = '0;
      cmd_pw    = '0;
      abort     = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) op_vol[i] = real'(i) + 0.5;
      op_vol[5] = 1.2;

      // Reset state
      #2;
      chk_r("rst_bl5", bl_out[5], 0.0);
      chk_r("rst_bl31", bl_out[31], 0.0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_ready", cmd_ready, 1'b1);
      chk_b("rst_done", done, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: WRITE addr 5, persistent level
      issue(OP_WRITE, 5, 1, 0);
      $display("txn WRITE addr=5 pw=0");
      chk_b("t1_busy", busy, 1'b1);
      chk_b("t1_ready_low", cmd_ready, 1'b0);
      step();
      chk_r("t1_bl5", bl_out[5], 1.2);
      chk_r("t1_bl4", bl_out[4], 0.0);
      chk_b("t1_done", done, 1'b1);
      chk_b("t1_err", err, 1'b0);
      step();
      chk_b("t1_ready_back", cmd_ready, 1'b1);
      chk_b("t1_done_clr", done, 1'b0);

      // 2: WRITE addr 13 pw 4 (uses source 5)
      op_vol[5] = 0.8;
      issue(OP_WRITE, 13, 1, 4);
      $display("txn WRITE addr=13 pw=4");
      chk_r("t2_bl13_pre", bl_out[13], 0.0);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk_r("t2_bl13_pulse", bl_out[13], 0.8);
         chk_b("t2_done_early", done, 1'b0);
      end
      step();
      chk_r("t2_bl13_rest", bl_out[13], 0.0);
      chk_b("t2_done", done, 1'b1);
      chk_r("t2_bl5_kept", bl_out[5], 1.2);
      step();

      // 3: SWEEP addr 30 len 4 pw 0 with wrap
      for (int i = 0; i < NUM_SRC; i++) op_vol[i] = real'(i) + 0.25;
      issue(OP_SWEEP, 30, 4, 0);
      $display("txn SWEEP addr=30 len=4 pw=0");
      dcount  = 0;
      done_at = 0;
      for (int c = 1; c <= 12; c++) begin
         if (done === 1'b1) begin
            dcount++;
            done_at = c;
         end
         step();
      end
      chk_i("t3_done_count", dcount, 1);
      chk_i("t3_done_cycle", done_at, 5);
      chk_r("t3_bl30", bl_out[30], 6.25);
      chk_r("t3_bl31", bl_out[31], 7.25);
      chk_r("t3_bl0", bl_out[0], 0.25);
      chk_r("t3_bl1", bl_out[1], 1.25);
      chk_r("t3_bl29", bl_out[29], 0.0);
      chk_r("t3_bl5", bl_out[5], 1.2);

      // 4: BCAST pw 2, op_vol changed mid-pulse
      for (int i = 0; i < NUM_SRC; i++) op_vol[i] = 2.0 + real'(i);
      issue(OP_BCAST, 0, 1, 2);
      $display("txn BCAST pw=2");
      for (int i = 0; i < NUM_SRC; i++) op_vol[i] = 9.0;
      for (int k = 2; k <= 3; k++) begin
         step();
         bad = 0;
         for (int i = 0; i < NUM_BL; i++)
            if (bl_out[i] != 2.0 + real'(i % NUM_SRC)) bad++;
         chk_i("t4_bcast_lvl", bad, 0);
         chk_b("t4_done_early", done, 1'b0);
      end
      step();
      bad = 0;
      for (int i = 0; i < NUM_BL; i++)
         if (bl_out[i] != 0.0) bad++;
      chk_i("t4_bcast_rest", bad, 0);
      chk_b("t4_done", done, 1'b1);
      step();

      // 5: rejected sweeps, and cmd_valid held while busy
      op_vol[0] = 3.3;
      issue(OP_WRITE, 8, 1, 0);
      step();
      step();
      chk_r("t5_bl8_set", bl_out[8], 3.3);
      issue(OP_SWEEP, 0, 0, 0);
      $display("txn SWEEP len=0");
      chk_b("t5_len0_done", done, 1'b1);
      chk_b("t5_len0_err", err, 1'b1);
      chk_r("t5_len0_bl8", bl_out[8], 3.3);
      step();
      chk_b("t5_len0_ready", cmd_ready, 1'b1);
      chk_b("t5_len0_done_clr", done, 1'b0);
      issue(OP_SWEEP, 0, 33, 0);
      $display("txn SWEEP len=33");
      chk_b("t5_len33_done", done, 1'b1);
      chk_b("t5_len33_err", err, 1'b1);
      step();
      issue(OP_WRITE, 9, 1, 3);
      $display("txn WRITE addr=9 pw=3 with cmd_valid held while busy");
      cmd_op    = OP_WRITE;
      cmd_addr  = AW'(20);
      cmd_pw    = '0;
      op_vol[4] = 5.5;
      cmd_valid = 1'b1;
      chk_b("t5_busy_ready", cmd_ready, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         step();
         chk_b("t5_busy_ready", cmd_ready, 1'b0);
      end
      step();
      cmd_valid = 1'b0;
      chk_b("t5_w9_done", done, 1'b1);
      chk_b("t5_w9_err", err, 1'b0);
      step();
      chk_b("t5_idle_ready", cmd_ready, 1'b1);
      chk_r("t5_bl20_untouched", bl_out[20], 0.0);
      chk_r("t5_bl9_rest", bl_out[9], 0.0);
      step();
      chk_b("t5_no_accept", busy, 1'b0);

      // 6: SWEEP pw 8, abort during HOLD of the second line
      for (int i = 0; i < NUM_SRC; i++) op_vol[i] = 4.0 + real'(i);
      issue(OP_SWEEP, 6, 4, 8);
      $display("txn SWEEP addr=6 len=4 pw=8 with abort");
      step();
      chk_r("t6_bl6_pulse", bl_out[6], 10.0);
      for (int k = 3; k <= 12; k++) step();
      chk_r("t6_bl7_pulse", bl_out[7], 11.0);
      chk_r("t6_bl6_rest", bl_out[6], 0.0);
      chk_b("t6_busy", busy, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_b("t6_restore_nodone", done, 1'b0);
      chk_r("t6_bl7_still", bl_out[7], 11.0);
      step();
      chk_r("t6_bl7_rest", bl_out[7], 0.0);
      chk_b("t6_done", done, 1'b1);
      chk_b("t6_err", err, 1'b1);
      chk_r("t6_bl8_untouched", bl_out[8], 3.3);
      step();
      chk_b("t6_ready", cmd_ready, 1'b1);
      chk_r("t6_bl8_after", bl_out[8], 3.3);

      // Async reset in the middle of a HOLD
      issue(OP_WRITE, 10, 1, 8);
      $display("txn WRITE addr=10 pw=8 with reset mid-hold");
      step();
      step();
      step();
      chk_r("t6_bl10_pulse", bl_out[10], 6.0);
      chk_b("t6_hold_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_r("t6_rst_bl10", bl_out[10], 0.0);
      chk_r("t6_rst_bl8", bl_out[8], 0.0);
      chk_b("t6_rst_busy", busy, 1'b0);
      chk_b("t6_rst_ready", cmd_ready, 1'b1);
      chk_b("t6_rst_done", done, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk_b("t6_post_rst_ready", cmd_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
